// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: request opcodes, FSM states,
// and alignment helpers used by lsu_ctrl.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input lsu_op_e op);
    return !(op inside {OP_SW, OP_SH, OP_SB});
  endfunction

  function automatic logic is_word(input lsu_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input lsu_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic misaligned(input lsu_op_e op, input logic [1:0] addr_lo);
    if (is_word(op)) return addr_lo != 2'b00;
    if (is_half(op)) return addr_lo[0];
    return 1'b0;
  endfunction

  // Drops the low address bits an access of this width cannot use.
  function automatic logic [31:0] force_align(input lsu_op_e op, input logic [31:0] addr);
    if (is_word(op)) return {addr[31:2], 2'b00};
    if (is_half(op)) return {addr[31:1], 1'b0};
    return addr;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: merges store data into a memory word and
// extracts/extends load data from it.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [4:0]  bit_off;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  assign bit_off = {addr_lo, 3'b000};

  always_comb begin
    half_v     = addr_lo[1] ? word[31:16] : word[15:0];
    byte_v     = word[bit_off +: 8];
    store_word = word;
    load_word  = '0;
    case (op)
      OP_SW:  store_word = wdata;
      OP_SH: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      OP_SB:  store_word[bit_off +: 8] = wdata[7:0];
      OP_LW:  load_word = word;
      OP_LH:  load_word = {{16{half_v[15]}}, half_v};
      OP_LHU: load_word = {16'h0000, half_v};
      OP_LB:  load_word = {{24{byte_v[7]}}, byte_v};
      OP_LBU: load_word = {24'h000000, byte_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, read-modify-write for
// sub-word stores. Define LSU_MISALIGN_CHECK_EN to report misaligned accesses.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_A,
  output logic [31:0] dm_WD,
  output logic        dm_WE,
  output logic [31:0] dm_PC,
  input  logic [31:0] dm_RD
);

  lsu_state_e  state;
  lsu_op_e     op_q;
  lsu_op_e     in_op;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic [31:0] word_q;
  logic [31:0] store_word;
  logic [31:0] load_word;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        err_q;
`endif

  assign in_op = lsu_op_e'(req_op);

  lsu_byte_lane u_lane (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .word       (word_q),
    .wdata      (wdata_q),
    .store_word (store_word),
    .load_word  (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      word_q  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= in_op;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
`ifdef LSU_MISALIGN_CHECK_EN
            addr_q  <= req_addr;
            if (misaligned(in_op, req_addr[1:0])) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              state <= (in_op == OP_SW) ? ST_WRITE : ST_READ;
            end
`else
            addr_q  <= force_align(in_op, req_addr);
            state   <= (in_op == OP_SW) ? ST_WRITE : ST_READ;
`endif
          end
        end
        // Sub-word stores read the old word first so the merge preserves other lanes.
        ST_READ: begin
          word_q <= dm_RD;
          state  <= is_load(op_q) ? ST_RESP : ST_WRITE;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    dm_WE      = (state == ST_WRITE);
    dm_A       = ((state == ST_READ) || (state == ST_WRITE)) ? {addr_q[31:2], 2'b00} : 32'h0;
    dm_WD      = (state == ST_WRITE) ? store_word : 32'h0;
    dm_PC      = pc_q;
`ifdef LSU_MISALIGN_CHECK_EN
    resp_err   = (state == ST_RESP) && err_q;
    resp_rdata = ((state == ST_RESP) && !err_q) ? load_word : 32'h0;
`else
    resp_err   = 1'b0;
    resp_rdata = (state == ST_RESP) ? load_word : 32'h0;
`endif
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on posedge clk.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 req_valid  input  1  CPU memory request present.
REQ-004 req_ready  output  1  lsu_ctrl accepts a request; a transfer occurs on a posedge where req_valid and req_ready are both high.
REQ-005 req_op  input  3  LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data, LSB-aligned.
REQ-008 req_pc  input  32  PC of the issuing instruction.
REQ-009 resp_valid  output  1  response present.
REQ-010 resp_ready  input  1  CPU consumes the response.
REQ-011 resp_rdata  output  32  load result after extension; 0 for stores.
REQ-012 resp_err  output  1  misaligned access.
REQ-013 dm_A  output  32  word-aligned byte address to DM; bits [1:0] always 0.
REQ-014 dm_WD  output  32  write word to DM.
REQ-015 dm_WE  output  1  DM write enable; DM writes on the posedge where it is high.
REQ-016 dm_PC  output  32  latched req_pc, forwarded for DM write logging.
REQ-017 dm_RD  input  32  DM combinational read data for dm_A.

Function
REQ-018 FSM states: IDLE, READ, WRITE, RESP; req_ready = (state==IDLE); no other request is accepted while busy.
REQ-019 On acceptance, latch op, addr, wdata and pc.
- Next state: READ for loads, SH and SB; WRITE for SW; RESP for misaligned accesses (see REQ-026).
REQ-020 READ (one cycle):
- dm_A = {addr[31:2],2'b00}; dm_RD captured into a word register at the closing edge.
- Next state: WRITE for SH/SB; RESP for loads.
REQ-021 WRITE (one cycle): dm_WE=1 and dm_WD driven as follows.
- SW: dm_WD=wdata.
- SH: captured word with halfword addr[1] replaced by wdata[15:0].
- SB: captured word with byte addr[1:0] replaced by wdata[7:0].
- Next state: RESP.
REQ-022 dm_WE is high only in WRITE; dm_WD is 0 outside WRITE; dm_A holds the latched aligned address in READ/WRITE and 0 elsewhere.
REQ-023 resp_rdata for loads, taken from the captured word:
- LW: full word.
- LH/LHU: halfword addr[1], sign-/zero-extended.
- LB/LBU: byte addr[1:0], sign-/zero-extended.
REQ-024 RESP: resp_valid=1 with resp_rdata/resp_err stable until resp_ready=1; next state is IDLE on that edge.
- resp_ready is ignored outside RESP.
REQ-025 Latency from acceptance edge to resp_valid high:
- SW: 2 cycles.
- Loads: 2 cycles.
- SH/SB: 3 cycles.
- Misaligned: 1 cycle.
REQ-026 Misaligned means: word op with addr[1:0]!=0, or half op with addr[0]=1. resp_err=1, resp_rdata=0, and no DM read or write occurs.
REQ-027 A request arriving while not IDLE is not accepted; req_valid may remain high and is accepted upon return to IDLE.

Reset
REQ-028 Reset forces state IDLE on the reset edge.
- Output values: req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; dm_WE=0, dm_A=0, dm_WD=0, dm_PC=0.
- All latched and captured registers clear to 0.
REQ-029 Reset sampled in any state, including WRITE, aborts the operation.
- No response is produced.
- dm_WE is low from the cycle after the reset edge.

Configuration
REQ-030 Macro LSU_MISALIGN_CHECK_EN.
- Defined: REQ-026 applies.
- Undefined: alignment bits are forced (word ops ignore addr[1:0], half ops ignore addr[0]), resp_err is tied 0, and misaligned requests follow the normal path.

Structure
REQ-031 Package lsu_pkg holds the req_op encodings and the FSM state enumeration.
REQ-032 Sub-module lsu_byte_lane (combinational) performs store merge and load extract/extend; lsu_ctrl instantiates it once.

Verification
REQ-033 SW addr 0x0, wdata 0x0000_000F, then LW 0x0 -> dm_WE pulses once with dm_WD=0x0000_000F; load resp_rdata=0x0000_000F two cycles after acceptance.
REQ-034 Word at 0x4 = 0x1234_5678; SB addr 0x5, wdata 0xAB -> READ then WRITE with dm_WD=0x1234_AB78; LBU 0x5 returns 0x0000_00AB; LB 0x5 returns 0xFFFF_FFAB.
REQ-035 Word at 0x8 = 0x8001_7FFF; LH 0x8 returns 0x0000_7FFF; LH 0xA returns 0xFFFF_8001; LHU 0xA returns 0x0000_8001.
REQ-036 LW 0x2 with macro defined -> resp_err=1, resp_rdata=0, dm_WE never high, resp_valid 1 cycle after acceptance; with macro undefined -> reads word at 0x0, resp_err=0.
REQ-037 Edge cases:
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stable and req_ready=0 throughout.
- Assert reset during WRITE of an SH -> state IDLE, dm_WE=0 after the edge, no resp_valid.
